// File: rtl/tick_stopwatch.sv
// tick_stopwatch: synchronises the slow divider-chain tick into the clk domain,
// edge-detects it into a one-cycle tick_pulse and drives an M:SS BCD stopwatch
// with an IDLE/RUN/PAUSE control FSM (priority clear > stop > start).
// Optional lap freeze is compiled in with `define TICK_STOPWATCH_LAP_EN.
module tick_stopwatch #(
  parameter int SYNC_STAGES = 2,  // 2..4
  parameter int MAX_MIN     = 9   // 1..9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic       tick_pulse,
  output logic [3:0] sec_units,
  output logic [2:0] sec_tens,
  output logic [3:0] min_units,
  output logic       running,
  output logic       overflow
);

  localparam logic [3:0] MAX_MIN_L = 4'(MAX_MIN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   tick_q, tick_d;
  logic                   running_q, running_d;

  logic [3:0] units_q, units_d;
  logic [2:0] tens_q, tens_d;
  logic [3:0] min_q, min_d;
  logic       ovf_q, ovf_d;
  logic       count_en;

  assign sync_d      = {sync_q[SYNC_STAGES-2:0], tick_in};
  assign sync_prev_d = sync_q[SYNC_STAGES-1];
  assign tick_d      = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Synchroniser chain, edge-detect history flop and registered tick pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      tick_q      <= tick_d;
    end
  end

  assign tick_pulse = tick_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (stop)  state_d = PAUSE;
        PAUSE:   if (!stop && start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM output decode, taken from the next state so running is a plain flop
  always_comb begin
    running_d = (state_d == RUN);
  end

  // Registered FSM output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) running_q <= 1'b0;
    else     running_q <= running_d;
  end

  assign running = running_q;

  // A tick seen while stop is asserted still counts: the state is still RUN
  assign count_en = (state_q == RUN) && tick_q && !clear;

  // BCD counter next value with cascaded carries and sticky wrap flag
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    min_d   = min_q;
    ovf_d   = ovf_q;
    if (clear) begin
      units_d = '0;
      tens_d  = '0;
      min_d   = '0;
      ovf_d   = 1'b0;
    end else if (count_en) begin
      if (units_q != 4'd9) begin
        units_d = units_q + 4'd1;
      end else begin
        units_d = '0;
        if (tens_q != 3'd5) begin
          tens_d = tens_q + 3'd1;
        end else begin
          tens_d = '0;
          if (min_q != MAX_MIN_L) begin
            min_d = min_q + 4'd1;
          end else begin
            min_d = '0;
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  // Live counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units_q <= '0;
      tens_q  <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

`ifdef TICK_STOPWATCH_LAP_EN
  logic        lap_prev_q;
  logic        frozen_q, frozen_d;
  logic [10:0] lap_q, lap_d;
  logic [10:0] disp_q, disp_d;
  logic        lap_rise;

  assign lap_rise = lap & ~lap_prev_q;

  // Lap freeze toggle: capture the shown value on a rise, release on the next
  always_comb begin
    frozen_d = frozen_q;
    lap_d    = lap_q;
    if (clear) begin
      frozen_d = 1'b0;
      lap_d    = '0;
    end else if (lap_rise) begin
      if (frozen_q) begin
        frozen_d = 1'b0;
      end else if (state_q == RUN || state_q == PAUSE) begin
        frozen_d = 1'b1;
        lap_d    = {min_q, tens_q, units_q};
      end
    end
  end

  // Display selection is computed from next values so the digits stay registered
  always_comb begin
    disp_d = frozen_d ? lap_d : {min_d, tens_d, units_d};
  end

  // Lap edge history, freeze flag, lap value and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_prev_q <= 1'b0;
      frozen_q   <= 1'b0;
      lap_q      <= '0;
      disp_q     <= '0;
    end else begin
      lap_prev_q <= lap;
      frozen_q   <= frozen_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
    end
  end

  assign {min_units, sec_tens, sec_units} = disp_q;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign {min_units, sec_tens, sec_units} = {min_q, tens_q, units_q};
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed self-checking bench for tick_stopwatch (SYNC_STAGES=2, MAX_MIN=9).
module tb_tick_stopwatch;

  localparam int SYNC = 2;

  logic       clk, rst, tick_in, start, stop, clear, lap;
  logic       tick_pulse;
  logic [3:0] sec_units;
  logic [2:0] sec_tens;
  logic [3:0] min_units;
  logic       running, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  tick_stopwatch #(.SYNC_STAGES(SYNC), .MAX_MIN(9)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .tick_pulse(tick_pulse), .sec_units(sec_units),
    .sec_tens(sec_tens), .min_units(min_units), .running(running),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {min_units, sec_tens, sec_units, running, overflow};

  function automatic logic [12:0] ev(int m, int t, int u, int r, int o);
    return {4'(m), 3'(t), 4'(u), 1'(r), 1'(o)};
  endfunction

  function automatic string show(logic [12:0] v);
    return $sformatf("%0d:%0d%0d run=%0d ovf=%0d", v[12:9], v[8:6], v[5:2], v[1], v[0]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    tick_in = 1'b1; cyc(4);
    tick_in = 1'b0; cyc(4);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    start = 0; stop = 0; clear = 0; lap = 0; tick_in = 0;
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    cyc(1);
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL reset_init: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
    n_checks++;
    if (tick_pulse !== 1'b0) $display("FAIL reset_pulse: got %0d expected 0", tick_pulse);
    else n_pass++;
    rst = 1'b0; cyc(1);
    pulse_start();
    ticks(3);
    n_checks++;
    if (obs !== ev(0,0,3,1,0)) $display("FAIL pre_reset_count: got %s expected %s", show(obs), show(ev(0,0,3,1,0)));
    else n_pass++;
    // asynchronous reset in the middle of a tick_in high phase
    tick_in = 1'b1; cyc(1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== ev(0,0,0,0,0) || tick_pulse !== 1'b0)
      $display("FAIL reset_async: got %s pulse=%0d expected %s pulse=0", show(obs), tick_pulse, show(ev(0,0,0,0,0)));
    else n_pass++;
    tick_in = 1'b0; cyc(2);
    rst = 1'b0; cyc(1);
    tick();
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL reset_idle: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
  endtask

  task automatic test_edge_detect();
    logic [7:0] pat;
    int total;
    do_reset();
    total = 0;
    for (int k = 0; k < 10; k++) begin
      pat = '0;
      tick_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (i == 4) tick_in = 1'b0;
        cyc(1);
        pat[i] = tick_pulse;
        if (tick_pulse === 1'b1) total++;
      end
      cyc(k % 3);
      // pulse only in the sample after SYNC+1 rising clk edges
      n_checks++;
      if (pat !== 8'b0000_0100) $display("FAIL edge_%0d: got %b expected %b", k, pat, 8'b0000_0100);
      else n_pass++;
    end
    n_checks++;
    if (total != 10) $display("FAIL edge_total: got %0d expected 10", total);
    else n_pass++;
  endtask

  task automatic test_count();
    do_reset();
    pulse_start();
    n_checks++;
    if (obs !== ev(0,0,0,1,0)) $display("FAIL count_start: got %s expected %s", show(obs), show(ev(0,0,0,1,0)));
    else n_pass++;
    ticks(9);
    n_checks++;
    if (obs !== ev(0,0,9,1,0)) $display("FAIL count_9: got %s expected %s", show(obs), show(ev(0,0,9,1,0)));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== ev(0,1,0,1,0)) $display("FAIL count_10: got %s expected %s", show(obs), show(ev(0,1,0,1,0)));
    else n_pass++;
    ticks(50);
    n_checks++;
    if (obs !== ev(1,0,0,1,0)) $display("FAIL count_60: got %s expected %s", show(obs), show(ev(1,0,0,1,0)));
    else n_pass++;
    ticks(15);
    n_checks++;
    if (obs !== ev(1,1,5,1,0)) $display("FAIL count_75: got %s expected %s", show(obs), show(ev(1,1,5,1,0)));
    else n_pass++;
  endtask

  // continues from 1:15 running
  task automatic test_pause();
    tick_in = 1'b1; cyc(SYNC + 1);
    n_checks++;
    if (tick_pulse !== 1'b1) $display("FAIL pause_pulse: got %0d expected 1", tick_pulse);
    else n_pass++;
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4 - SYNC - 2);
    tick_in = 1'b0; cyc(4);
    n_checks++;
    if (obs !== ev(1,1,6,0,0)) $display("FAIL pause_stop_tick: got %s expected %s", show(obs), show(ev(1,1,6,0,0)));
    else n_pass++;
    ticks(3);
    n_checks++;
    if (obs !== ev(1,1,6,0,0)) $display("FAIL pause_hold: got %s expected %s", show(obs), show(ev(1,1,6,0,0)));
    else n_pass++;
    pulse_start();
    tick();
    n_checks++;
    if (obs !== ev(1,1,7,1,0)) $display("FAIL pause_resume: got %s expected %s", show(obs), show(ev(1,1,7,1,0)));
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    stop = 1'b1; cyc(1); stop = 1'b0;
    tick();
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL prio_stop_idle: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
    pulse_start();
    tick();
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    tick();
    n_checks++;
    if (obs !== ev(0,0,1,0,0)) $display("FAIL prio_start_stop: got %s expected %s", show(obs), show(ev(0,0,1,0,0)));
    else n_pass++;
    pulse_start();
    clear = 1'b1; start = 1'b1; stop = 1'b1; cyc(1);
    clear = 1'b0; start = 1'b0; stop = 1'b0; cyc(1);
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL prio_clear: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_start();
    ticks(599);
    n_checks++;
    if (obs !== ev(9,5,9,1,0)) $display("FAIL wrap_959: got %s expected %s", show(obs), show(ev(9,5,9,1,0)));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== ev(0,0,0,1,1)) $display("FAIL wrap_000: got %s expected %s", show(obs), show(ev(0,0,0,1,1)));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== ev(0,0,1,1,1)) $display("FAIL wrap_continue: got %s expected %s", show(obs), show(ev(0,0,1,1,1)));
    else n_pass++;
    tick_in = 1'b1; cyc(SYNC + 1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    cyc(4 - SYNC - 2);
    tick_in = 1'b0; cyc(4);
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL wrap_clear_tick: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL wrap_after_clear: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
  endtask

`ifdef TICK_STOPWATCH_LAP_EN
  task automatic test_lap();
    do_reset();
    pulse_start();
    ticks(12);
    lap = 1'b1; cyc(1);
    n_checks++;
    if (obs !== ev(0,1,2,1,0)) $display("FAIL lap_capture: got %s expected %s", show(obs), show(ev(0,1,2,1,0)));
    else n_pass++;
    ticks(5);
    n_checks++;
    if (obs !== ev(0,1,2,1,0)) $display("FAIL lap_frozen: got %s expected %s", show(obs), show(ev(0,1,2,1,0)));
    else n_pass++;
    lap = 1'b0; cyc(1); lap = 1'b1; cyc(1);
    n_checks++;
    if (obs !== ev(0,1,7,1,0)) $display("FAIL lap_release: got %s expected %s", show(obs), show(ev(0,1,7,1,0)));
    else n_pass++;
    lap = 1'b0; cyc(1); lap = 1'b1; cyc(1); lap = 1'b0;
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
    n_checks++;
    if (obs !== ev(0,0,0,0,0)) $display("FAIL lap_clear: got %s expected %s", show(obs), show(ev(0,0,0,0,0)));
    else n_pass++;
  endtask
`else
  task automatic test_lap();
    do_reset();
    pulse_start();
    ticks(2);
    lap = 1'b1; cyc(1);
    tick();
    n_checks++;
    if (obs !== ev(0,0,3,1,0)) $display("FAIL lap_ignored: got %s expected %s", show(obs), show(ev(0,0,3,1,0)));
    else n_pass++;
    lap = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; tick_in = 0; start = 0; stop = 0; clear = 0; lap = 0;
    test_reset();
    test_edge_detect();
    test_count();
    test_pause();
    test_priority();
    test_lap();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
